simple_ram_responder: RTL

- Memory-side responder for the 14-bit-address / 32-bit-data CPU memory interface (addr_toRAM, wrEn, data_toRAM in; data_fromRAM out).
- Synchronous single-port RAM with a one-cycle registered read. This matches the CPU's request-in-state-N, consume-in-state-N+1 access pattern.
- Adds a host program-load port with a valid/ready handshake. A small mode FSM arbitrates between CPU and loader and holds the CPU off the bus during loading.

---
 rtl/simple_ram_responder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/simple_ram_responder.sv
// rtl/simple_ram_responder.sv - CPU-side synchronous RAM with host program-load port
//
// Purpose:
//   Single-port word RAM serving the CPU memory interface with a one-cycle
//   registered read (read-first on read-during-write). A three-state mode FSM
//   (RUN / LOAD / DRAIN) hands the RAM to a host loader and holds the CPU in
//   reset while loading. Accesses at or beyond DEPTH are dropped (reads return
//   0) and raise a sticky error flag.
//
// Optional feature:
//   RAM_ACCESS_CNT_EN - when defined, adds saturating 16-bit counters of
//   in-range RUN-mode read cycles (rd_cnt) and write cycles (wr_cnt).
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous reset, active-low
//   addr_toRAM    in   CPU word address            [SIZE]
//   wrEn          in   CPU write enable
//   data_toRAM    in   CPU write data              [WIDTH]
//   data_fromRAM  out  registered read data        [WIDTH]
//   ld_req        in   host requests load mode (level)
//   ld_valid      in   host load word valid
//   ld_ready      out  load word accepted this cycle
//   ld_addr       in   load word address           [SIZE]
//   ld_data       in   load word data              [WIDTH]
//   cpu_hold      out  CPU must be held in reset
//   err_oor       out  sticky out-of-range access flag
//   rd_cnt        out  RUN read-cycle count  [16]  (RAM_ACCESS_CNT_EN only)
//   wr_cnt        out  RUN write-cycle count [16]  (RAM_ACCESS_CNT_EN only)

module simple_ram_responder #(
    parameter int SIZE  = 14,
    parameter int WIDTH = 32,
    parameter int DEPTH = 16384
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SIZE-1:0]  addr_toRAM,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] data_toRAM,
    output logic [WIDTH-1:0] data_fromRAM,
    input  logic             ld_req,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [SIZE-1:0]  ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic             cpu_hold,
`ifdef RAM_ACCESS_CNT_EN
    output logic [15:0]      rd_cnt,
    output logic [15:0]      wr_cnt,
`endif
    output logic             err_oor
);

    // Index width of the implemented array; addresses are sliced to this once
    // they are known to be in range.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH held one bit wider than an address so DEPTH == 2**SIZE is
    // representable and the range compare is then always true.
    localparam logic [SIZE:0] DEPTH_L = (SIZE+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic             r_ld_ready;
    logic             r_cpu_hold;
    logic [WIDTH-1:0] r_data;
    logic             r_err;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_run;
    logic             w_cpu_in_range;
    logic             w_ld_in_range;
    logic             w_ld_fire;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_waddr;
    logic [WIDTH-1:0] w_mem_wdata;
    logic [AW-1:0]    w_cpu_idx;

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:   if (ld_req)  w_next_state = ST_LOAD;
            ST_LOAD:  if (!ld_req) w_next_state = ST_DRAIN;
            ST_DRAIN: w_next_state = ST_RUN;
            default:  w_next_state = ST_RUN;
        endcase
    end

    // Handshake/hold outputs are flops loaded from the next state so they
    // change on the same edge as the mode itself.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_ld_ready <= 1'b0;
            r_cpu_hold <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ld_ready <= (w_next_state == ST_LOAD);
            r_cpu_hold <= (w_next_state != ST_RUN);
        end
    end

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign w_run          = (r_state == ST_RUN);
    assign w_cpu_in_range = ({1'b0, addr_toRAM} < DEPTH_L);
    assign w_ld_in_range  = ({1'b0, ld_addr} < DEPTH_L);
    // r_ld_ready is high exactly while in LOAD, so a word offered on the
    // cycle ld_req drops is still taken.
    assign w_ld_fire      = r_ld_ready && ld_valid;
    assign w_cpu_idx      = addr_toRAM[AW-1:0];

    // One write port shared by CPU (RUN) and loader (LOAD); the modes are
    // exclusive so a simple mux suffices. No writes while reset is asserted.
    assign w_mem_we    = rst && ((w_run && wrEn && w_cpu_in_range) ||
                                 (w_ld_fire && w_ld_in_range));
    assign w_mem_waddr = w_run ? addr_toRAM[AW-1:0] : ld_addr[AW-1:0];
    assign w_mem_wdata = w_run ? data_toRAM : ld_data;

    // ------------------------------------------------------------------
    // Storage (not reset: contents survive rst)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Registered read; non-blocking ordering gives read-first behaviour.
    // Outside RUN the read register holds its last value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data <= '0;
        end else if (w_run) begin
            r_data <= w_cpu_in_range ? r_mem[w_cpu_idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if ((w_run && !w_cpu_in_range) || (w_ld_fire && !w_ld_in_range)) begin
            r_err <= 1'b1;
        end
    end

`ifdef RAM_ACCESS_CNT_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (w_run && w_cpu_in_range) begin
            if (!wrEn && (r_rd_cnt != 16'hFFFF)) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            if (wrEn && (r_wr_cnt != 16'hFFFF)) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
`endif

    assign data_fromRAM = r_data;
    assign ld_ready     = r_ld_ready;
    assign cpu_hold     = r_cpu_hold;
    assign err_oor      = r_err;

endmodule
